flappy_game_ctrl: RTL and testbench
===================================

# flappy_game_ctrl

Game controller for the bird. It produces the `state[1:0]` bus that the pipe generator consumes, and it consumes that generator's `pip_X`/`pip_Y` outputs. It also owns bird vertical physics (position, velocity, gravity, flap), debounced-button edge detection, and pipe/floor collision. It sits between the button input, the pipe generator and the VGA renderer, all on the `clk_2ms` game tick.

## Interface
Parameters:
- `SLOT_WIDTH`, 100: pipe width in px. A pipe spans x ∈ [pip_X−SLOT_WIDTH, pip_X).
- `SLOT_HEIGHT`, 100: gap height in px. The gap spans y ∈ [pip_Y−SLOT_HEIGHT, pip_Y).
- `BIRD_HPOS`, 320: bird right edge. The bird spans x ∈ [BIRD_HPOS−BIRD_XWIDTH, BIRD_HPOS).
- `BIRD_XWIDTH`, 34: bird width.
- `BIRD_H`, 24: bird height. The bird spans y ∈ [bird_Y, bird_Y+BIRD_H).
- `BIRD_Y0`, 228: start/idle top coordinate.
- `FLAP_VEL`, 6: upward velocity magnitude set on a flap.
- `VMAX`, 8: terminal downward velocity.
- `TICK_DIV`, 8: clk_2ms cycles per physics step (16 ms).

Ports:
- `clk_2ms` in 1: game tick clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in 1: debounced flap button, level, asynchronous to clk_2ms.
- `pip_X` in 10: pipe right edge, 0..740.
- `pip_Y` in 9: gap bottom, 100..479.
- `state` out 2: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER.
- `bird_Y` out 9: bird top coordinate, 0..480−BIRD_H.
- `hit` out 1: one-cycle pulse on entering DYING.
- `game_over` out 1: high exactly while state==OVER.

## Operation
- **Button path**
  - Two-flop synchronizer (`s1`, `s2`) plus previous-value flop `s3`.
  - `flap = s2 & ~s3`, a single-cycle pulse per rising edge.
  - Holding `btn` gives exactly one flap.
- **Physics registers**
  - `vel` is signed 8-bit, positive = down.
  - `tick_cnt` runs 0..TICK_DIV−1.
  - A step occurs when tick_cnt==TICK_DIV−1. The counter wraps to 0 and runs only in PLAY and DYING; it is held at 0 in IDLE and OVER.
- **Step update**
  - `bird_Y ← clamp(bird_Y + vel, 0, 480−BIRD_H)`, computed in 11-bit signed.
  - `vel ← min(vel+1, VMAX)`.
- **Flap in PLAY**: `vel ← −FLAP_VEL`. This overrides a coincident step's vel update; that step's position still uses the old vel.
- **Collision (PLAY only, combinational on registered values)**
  - Horizontal overlap: pip_X > BIRD_HPOS−BIRD_XWIDTH and pip_X < BIRD_HPOS+SLOT_WIDTH (default 287..419).
  - Pipe hit: horizontal overlap and (bird_Y < pip_Y−SLOT_HEIGHT or bird_Y+BIRD_H > pip_Y).
  - Floor hit: bird_Y == 480−BIRD_H.
  - All comparisons are unsigned, widened to 11 bits.
- **FSM**
  - IDLE: bird_Y=BIRD_Y0, vel=0. flap → PLAY with vel=−FLAP_VEL.
  - PLAY: pipe or floor hit → DYING, hit=1 for one cycle. Flap and hit in the same cycle: hit wins, vel is not changed.
  - DYING: flaps are ignored and physics continues. Floor reached (bird_Y==480−BIRD_H) → OVER, then vel=0.
  - OVER: everything is held. flap → IDLE (bird_Y=BIRD_Y0, vel=0).
- Ceiling clamp at 0 is not a collision.

## Timing
- Reset (asynchronous, any state, including mid-PLAY):
  - state=0, bird_Y=BIRD_Y0, vel=0, tick_cnt=0, hit=0, game_over=0, sync flops=0.
- Release is synchronous to the next clk_2ms edge.
- Flap latency:
  - `btn` sampled high at edge k.
  - `flap` is high after edge k+2.
  - state/vel change at edge k+3.
- Collision latency: the condition true after edge n gives state=2 and hit=1 after edge n+1; hit clears after n+2.
- Floor hit in PLAY:
  - PLAY → DYING at edge n+1.
  - DYING → OVER at edge n+2, because the floor condition still holds.
- All outputs are registered except game_over, which is decoded from the state register.

## Structure
- Shared package `flappy_pkg`:
  - State encodings `ST_IDLE`..`ST_OVER`.
  - Screen constants 640/480.
  - SLOT_WIDTH/SLOT_HEIGHT/BIRD_HPOS/BIRD_XWIDTH defaults, shared with the pipe generator.
- Sub-module `flap_edge_sync`: synchronizer plus rising-edge pulse, ports clk_2ms/rst_n/btn/flap.
- Physics, collision and the FSM stay in the top module.

## Test plan
- **Reset**: assert rst_n=0 mid-PLAY with bird_Y=300 → immediately state=0, bird_Y=228, hit=0, game_over=0.
- **Start**: btn 0→1 in IDLE → state=1 exactly 3 edges later, vel=−6. Holding btn for 100 cycles gives no further flap.
- **Free fall**: pip_X=0, no flaps → bird rises to 228−6−5−…, then falls to 456. hit pulses once, state goes 1→2→3 on consecutive edges, game_over=1.
- **Gap pass/hit**: pip_X=350, pip_Y=300.
  - bird_Y=240 → no hit.
  - bird_Y=199 → hit (199<200).
  - bird_Y=277 → hit (301>300).
  - bird_Y=276 → no hit.
- **X boundaries**: pip_Y=150, bird_Y=240.
  - pip_X=286 → no hit.
  - pip_X=287 → hit.
  - pip_X=419 → hit.
  - pip_X=420 → no hit.
- **Restart**: in OVER, btn rise → state=0, bird_Y=228. A flap in DYING leaves vel unchanged.

Source files
------------

// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the flappy game blocks: game state encoding, screen
// geometry and the default pipe/bird geometry also used by the pipe generator.
// Also holds the vertical clamp helper used by the bird physics.
// -----------------------------------------------------------------------------
package flappy_pkg;

  // Game state, also exported on the state[1:0] bus to the pipe generator
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int SLOT_WIDTH_DEF  = 100;
  localparam int SLOT_HEIGHT_DEF = 100;
  localparam int BIRD_HPOS_DEF   = 320;
  localparam int BIRD_XWIDTH_DEF = 34;

  // Clamp an 11-bit two's-complement position into [0, hi].
  // A set bit 10 means the sum went negative (above the ceiling).
  function automatic logic [8:0] clamp_y(input logic [10:0] sum, input logic [10:0] hi);
    logic [8:0] res;
    if (sum[10]) begin
      res = 9'd0;
    end else if (sum > hi) begin
      res = hi[8:0];
    end else begin
      res = sum[8:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/flap_edge_sync.sv
// -----------------------------------------------------------------------------
// flap_edge_sync
// Brings the asynchronous flap button into the clk_2ms domain and turns each
// rising edge into a single-cycle registered flap pulse.
// Ports:
//   clk_2ms - game tick clock
//   rst_n   - asynchronous active-low reset
//   btn     - debounced button level, asynchronous to clk_2ms
//   flap    - one-cycle pulse per button press (registered)
// -----------------------------------------------------------------------------
module flap_edge_sync
  import flappy_pkg::*;
(
  input  logic clk_2ms,
  input  logic rst_n,
  input  logic btn,
  output logic flap
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic flap_q, flap_d;

  // Next values: two-stage synchronizer, previous-value flop, edge pulse
  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    s3_d   = s2_q;
    // s3 lags s2 by one cycle, so this is high for exactly one cycle per rise
    flap_d = s2_q & ~s3_q;
  end

  // Synchronizer, edge-detect and pulse registers
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      flap_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      flap_q <= flap_d;
    end
  end

  assign flap = flap_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
// Game controller: bird vertical physics (gravity, flap, ceiling/floor clamp),
// pipe and floor collision, and the IDLE/PLAY/DYING/OVER game FSM.
// Ports:
//   clk_2ms   - game tick clock
//   rst_n     - asynchronous active-low reset
//   btn       - debounced flap button (asynchronous level)
//   pip_X     - pipe right edge from the pipe generator (0..740)
//   pip_Y     - gap bottom from the pipe generator (100..479)
//   state     - game state: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER
//   bird_Y    - bird top coordinate
//   hit       - one-cycle pulse on entering DYING
//   game_over - high while in OVER
// -----------------------------------------------------------------------------
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int SLOT_WIDTH  = SLOT_WIDTH_DEF,
  parameter int SLOT_HEIGHT = SLOT_HEIGHT_DEF,
  parameter int BIRD_HPOS   = BIRD_HPOS_DEF,
  parameter int BIRD_XWIDTH = BIRD_XWIDTH_DEF,
  parameter int BIRD_H      = 24,
  parameter int BIRD_Y0     = 228,
  parameter int FLAP_VEL    = 6,
  parameter int VMAX        = 8,
  parameter int TICK_DIV    = 8
) (
  input  logic       clk_2ms,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [9:0] pip_X,
  input  logic [8:0] pip_Y,
  output logic [1:0] state,
  output logic [8:0] bird_Y,
  output logic       hit,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  // All geometry compares are done unsigned in 11 bits
  localparam logic [10:0] X_LO     = 11'(BIRD_HPOS - BIRD_XWIDTH);
  localparam logic [10:0] X_HI     = 11'(BIRD_HPOS + SLOT_WIDTH);
  localparam logic [10:0] Y_FLOOR  = 11'(SCREEN_H - BIRD_H);
  localparam logic [10:0] GAP_H    = 11'(SLOT_HEIGHT);
  localparam logic [10:0] BIRD_H_W = 11'(BIRD_H);
  localparam logic [8:0]  Y_START  = 9'(BIRD_Y0);

  localparam logic signed [7:0] VEL_FLAP = 8'(-FLAP_VEL);
  localparam logic signed [8:0] VEL_MAX  = 9'(VMAX);
  localparam logic signed [7:0] VEL_MAX8 = 8'(VMAX);

  state_e                state_q, state_d;
  logic [8:0]            bird_y_q, bird_y_d;
  logic signed [7:0]     vel_q, vel_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic                  hit_q, hit_d;

  logic                  flap;
  logic                  run;
  logic                  step;
  logic                  pipe_hit;
  logic                  floor_hit;
  logic [10:0]           pip_x_w;
  logic [10:0]           pip_y_w;
  logic [10:0]           bird_w;
  logic [10:0]           gap_top;
  logic [10:0]           y_sum;
  logic signed [8:0]     vel_inc;
  logic [8:0]            bird_y_step;
  logic signed [7:0]     vel_step;

  flap_edge_sync u_flap_edge_sync (
    .clk_2ms (clk_2ms),
    .rst_n   (rst_n),
    .btn     (btn),
    .flap    (flap)
  );

  // Collision detection on registered bird position and current pipe inputs
  always_comb begin
    pip_x_w   = {1'b0, pip_X};
    pip_y_w   = {2'b00, pip_Y};
    bird_w    = {2'b00, bird_y_q};
    gap_top   = pip_y_w - GAP_H;
    floor_hit = (bird_w == Y_FLOOR);
    if ((pip_x_w > X_LO) && (pip_x_w < X_HI)) begin
      pipe_hit = (bird_w < gap_top) || ((bird_w + BIRD_H_W) > pip_y_w);
    end else begin
      pipe_hit = 1'b0;
    end
  end

  // Physics step candidates: clamped position and gravity-limited velocity
  always_comb begin
    run         = (state_q == ST_PLAY) || (state_q == ST_DYING);
    step        = run && (tick_q == TICK_LAST);
    y_sum       = bird_w + {{3{vel_q[7]}}, vel_q};
    bird_y_step = clamp_y(y_sum, Y_FLOOR);
    // One extra bit so vel+1 cannot wrap before the terminal-velocity limit
    vel_inc     = {vel_q[7], vel_q} + 9'sd1;
    if (vel_inc > VEL_MAX) begin
      vel_step = VEL_MAX8;
    end else begin
      vel_step = vel_inc[7:0];
    end
  end

  // Game FSM next state, position, velocity and hit pulse
  always_comb begin
    state_d  = state_q;
    bird_y_d = bird_y_q;
    vel_d    = vel_q;
    hit_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bird_y_d = Y_START;
        if (flap) begin
          state_d = ST_PLAY;
          vel_d   = VEL_FLAP;
        end else begin
          vel_d   = 8'sd0;
        end
      end
      ST_PLAY: begin
        if (step) begin
          bird_y_d = bird_y_step;
          vel_d    = vel_step;
        end else begin
          bird_y_d = bird_y_q;
        end
        // A collision beats a coincident flap; a flap beats the step's gravity
        if (pipe_hit || floor_hit) begin
          state_d = ST_DYING;
          hit_d   = 1'b1;
        end else if (flap) begin
          vel_d   = VEL_FLAP;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_DYING: begin
        if (floor_hit) begin
          state_d = ST_OVER;
          vel_d   = 8'sd0;
        end else if (step) begin
          bird_y_d = bird_y_step;
          vel_d    = vel_step;
        end else begin
          state_d = ST_DYING;
        end
      end
      ST_OVER: begin
        if (flap) begin
          state_d  = ST_IDLE;
          bird_y_d = Y_START;
          vel_d    = 8'sd0;
        end else begin
          state_d  = ST_OVER;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bird_y_d = Y_START;
        vel_d    = 8'sd0;
      end
    endcase
  end

  // Physics tick divider: counts only while staying in PLAY/DYING
  always_comb begin
    if (run && !step && ((state_d == ST_PLAY) || (state_d == ST_DYING))) begin
      tick_d = tick_q + TICK_ONE;
    end else begin
      tick_d = {TW{1'b0}};
    end
  end

  // State, physics and hit registers
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bird_y_q <= Y_START;
      vel_q    <= 8'sd0;
      tick_q   <= {TW{1'b0}};
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bird_y_q <= bird_y_d;
      vel_q    <= vel_d;
      tick_q   <= tick_d;
      hit_q    <= hit_d;
    end
  end

  assign state     = state_q;
  assign bird_Y    = bird_y_q;
  assign hit       = hit_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flappy_game_ctrl
// Scoreboard bench: stimulus pushes expected output events (state change, hit
// pulse, or an explicit probe) with the clock count at which they must appear;
// a monitor samples on the falling edge and compares each event in order.
// -----------------------------------------------------------------------------
module tb_flappy_game_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  typedef struct {
    logic [1:0] st;
    logic       hit;
    logic [8:0] y;
    logic       go;
    int         stamp;
    string      name;
  } ev_t;

  logic       clk_2ms = 1'b0;
  logic       rst_n   = 1'b1;
  logic       btn     = 1'b0;
  logic [9:0] pip_X   = 10'd0;
  logic [8:0] pip_Y   = 9'd240;
  logic [1:0] state;
  logic [8:0] bird_Y;
  logic       hit;
  logic       game_over;

  ev_t  exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic probe   = 1'b0;
  logic done    = 1'b0;

  flappy_game_ctrl dut (
    .clk_2ms   (clk_2ms),
    .rst_n     (rst_n),
    .btn       (btn),
    .pip_X     (pip_X),
    .pip_Y     (pip_Y),
    .state     (state),
    .bird_Y    (bird_Y),
    .hit       (hit),
    .game_over (game_over)
  );

  initial forever #5 clk_2ms = ~clk_2ms;

  initial forever begin
    @(posedge clk_2ms);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [1:0] st, input logic h, input logic [8:0] y,
                      input logic go, input int stamp, input string name);
    ev_t e;
    e.st = st; e.hit = h; e.y = y; e.go = go; e.stamp = stamp; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk_2ms);
      #1;
    end
  endtask

  // Ask the monitor to compare outputs on this cycle's falling edge
  task automatic do_probe(input logic [1:0] st, input logic h, input logic [8:0] y,
                          input logic go, input string name);
    push(st, h, y, go, cyc, name);
    probe = 1'b1;
    @(negedge clk_2ms);
    #1;
    probe = 1'b0;
    wait_cyc(cyc + 1);
  endtask

  task automatic apply_reset(input logic [1:0] cur_st);
    if (cur_st != S_IDLE) push(S_IDLE, 1'b0, 9'd228, 1'b0, cyc, "async_reset");
    rst_n = 1'b0;
    wait_cyc(cyc + 2);
    rst_n = 1'b1;
    wait_cyc(cyc + 2);
  endtask

  // Start a game with the given pipe; bird sits at 228 for the first PLAY cycles
  task automatic run_case(input logic [9:0] px, input logic [8:0] py,
                          input logic exp_hit, input string name);
    int c;
    c     = cyc;
    pip_X = px;
    pip_Y = py;
    btn   = 1'b1;
    push(S_PLAY, 1'b0, 9'd228, 1'b0, c + 4, {name, "_start"});
    if (exp_hit) push(S_DYING, 1'b1, 9'd228, 1'b0, c + 5, {name, "_hit"});
    wait_cyc(c + 4);
    btn = 1'b0;
    wait_cyc(c + 8);
    apply_reset(exp_hit ? S_DYING : S_PLAY);
    pip_X = 10'd0;
  endtask

  // Monitor: compare every output event against the scoreboard, in order
  initial begin
    logic [1:0] prev_st;
    ev_t        e;
    prev_st = S_IDLE;
    forever begin
      @(negedge clk_2ms);
      if (done) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL %s: event never seen, wanted st=%0d hit=%0d y=%0d go=%0d at cyc=%0d",
                   e.name, e.st, e.hit, e.y, e.go, e.stamp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end else if (probe || (state != prev_st) || hit) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got st=%0d hit=%0d y=%0d go=%0d at cyc=%0d, wanted no event",
                   state, hit, bird_Y, game_over, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((state !== e.st) || (hit !== e.hit) || (bird_Y !== e.y) ||
              (game_over !== e.go) || (cyc != e.stamp)) begin
            n_fail++;
            $display("FAIL %s: got st=%0d hit=%0d y=%0d go=%0d cyc=%0d, wanted st=%0d hit=%0d y=%0d go=%0d cyc=%0d",
                     e.name, state, hit, bird_Y, game_over, cyc,
                     e.st, e.hit, e.y, e.go, e.stamp);
          end
        end
      end
      prev_st = state;
    end
  end

  // Directed stimulus
  initial begin
    int c0, c1, c2, c3, c4;

    #1 rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    do_probe(S_IDLE, 1'b0, 9'd228, 1'b0, "reset_state");

    // Free fall, button held 100 cycles (single flap). Steps at c0+4+8j:
    // y 222,217,213,210,208,207,207,208,...,228(j13),235,243(j15), then +8,
    // j41=451, j42 clamps to 456 at edge c0+340 -> DYING c0+341, OVER c0+342.
    c0  = cyc;
    btn = 1'b1;
    push(S_PLAY, 1'b0, 9'd228, 1'b0, c0 + 4, "start_latency");
    wait_cyc(c0 + 53);
    do_probe(S_PLAY, 1'b0, 9'd207, 1'b0, "apex");
    wait_cyc(c0 + 100);
    btn = 1'b0;
    push(S_DYING, 1'b1, 9'd456, 1'b0, c0 + 341, "floor_hit");
    push(S_OVER,  1'b0, 9'd456, 1'b1, c0 + 342, "floor_over");
    wait_cyc(c0 + 360);
    do_probe(S_OVER, 1'b0, 9'd456, 1'b1, "over_hold");

    // Restart from OVER
    c1  = cyc;
    btn = 1'b1;
    push(S_IDLE, 1'b0, 9'd228, 1'b0, c1 + 4, "restart");
    wait_cyc(c1 + 10);
    btn = 1'b0;
    wait_cyc(c1 + 20);

    // Gap edges with bird at 228 (bird spans 228..251)
    run_case(10'd350, 9'd300, 1'b0, "gap_inside");
    run_case(10'd350, 9'd329, 1'b1, "gap_top_hit");
    run_case(10'd350, 9'd328, 1'b0, "gap_top_ok");
    run_case(10'd350, 9'd251, 1'b1, "gap_bot_hit");
    run_case(10'd350, 9'd252, 1'b0, "gap_bot_ok");
    // Horizontal edges, bird outside the gap
    run_case(10'd286, 9'd150, 1'b0, "x_286");
    run_case(10'd287, 9'd150, 1'b1, "x_287");
    run_case(10'd419, 9'd150, 1'b1, "x_419");
    run_case(10'd420, 9'd150, 1'b0, "x_420");

    // Flap during DYING must not touch velocity: floor timing equals free fall
    c2    = cyc;
    pip_X = 10'd350;
    pip_Y = 9'd150;
    btn   = 1'b1;
    push(S_PLAY,  1'b0, 9'd228, 1'b0, c2 + 4, "dying_start");
    push(S_DYING, 1'b1, 9'd228, 1'b0, c2 + 5, "dying_hit");
    wait_cyc(c2 + 8);
    btn   = 1'b0;
    pip_X = 10'd0;
    wait_cyc(c2 + 100);
    btn = 1'b1;
    push(S_OVER, 1'b0, 9'd456, 1'b1, c2 + 341, "dying_flap_ignored");
    wait_cyc(c2 + 110);
    btn = 1'b0;
    wait_cyc(c2 + 350);

    c3  = cyc;
    btn = 1'b1;
    push(S_IDLE, 1'b0, 9'd228, 1'b0, c3 + 4, "restart2");
    wait_cyc(c3 + 10);
    btn = 1'b0;
    wait_cyc(c3 + 20);

    // Mid-PLAY reset: step j22 (edge c4+180) puts the bird at 299
    c4  = cyc;
    btn = 1'b1;
    push(S_PLAY, 1'b0, 9'd228, 1'b0, c4 + 4, "start3");
    wait_cyc(c4 + 10);
    btn = 1'b0;
    wait_cyc(c4 + 182);
    do_probe(S_PLAY, 1'b0, 9'd299, 1'b0, "mid_play_y");
    apply_reset(S_PLAY);

    wait_cyc(cyc + 3);
    done = 1'b1;
  end

endmodule
